sr_pulse_gen: RTL



---
 rtl/sr_pulse_gen.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/sr_pulse_gen.sv
// sr_pulse_gen
// Front end for a gated RS trigger. Two raw push-buttons are synchronized and
// debounced. Each accepted press becomes one framed command for the trigger:
// the S or R level is set up for one cycle, the gate C is then held high for
// PULSE_LEN cycles, and the level is held for one more cycle after C drops.
// Because of this framing the trigger never sees glitches, overlapping S/R,
// or S=R=1.
//
// Parameters:
//   DEB_CYCLES  consecutive differing samples needed to accept a new level (>=1)
//   PULSE_LEN   number of cycles C is high per command (>=1)
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   btn_set   raw set button, asynchronous, active-high
//   btn_rst   raw reset button, asynchronous, active-high
//   S, R      set / reset levels to the trigger
//   C         latch enable (gate) to the trigger
//   busy      high while a command frame is in progress
//   conflict  one-cycle flag: both presses were accepted on the same cycle
module sr_pulse_gen #(
  parameter int DEB_CYCLES = 16,
  parameter int PULSE_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_rst,
  output logic S,
  output logic R,
  output logic C,
  output logic busy,
  output logic conflict
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int GATE_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    GATE,
    HOLD
  } state_t;

  // Bit 0 of every pair carries the set button, bit 1 the reset button.
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] stable;
  logic [1:0] stable_q;
  logic [DEB_W-1:0] deb_cnt [2];

  logic [1:0] rise;
  logic       rise_set_eff;
  logic       pend_set;
  logic       pend_rst;
  logic       take_set;
  logic       take_rst;

  state_t              state;
  state_t              next_state;
  logic                cmd_rst;
  logic [GATE_W-1:0]   gate_cnt;

  // Two-flop synchronizer for both buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {btn_rst, btn_set};
      sync2 <= sync1;
    end
  end

  // Debouncer: the accepted level only flips after DEB_CYCLES consecutive
  // synchronized samples disagree with it; any agreeing sample restarts the
  // count. stable_q keeps the previous accepted level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable     <= '0;
      stable_q   <= '0;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      stable_q <= stable;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != stable[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            stable[i]  <= ~stable[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Only rising edges of the accepted level are requests. When both rise on
  // the same cycle the set request is dropped so the trigger only sees reset.
  assign rise         = stable & ~stable_q;
  assign rise_set_eff = rise[0] & ~rise[1];

  // A command is taken only from IDLE, reset first.
  assign take_rst = (state == IDLE) && pend_rst;
  assign take_set = (state == IDLE) && !pend_rst && pend_set;

  // Pending flags hold at most one request per type; a new edge arriving on
  // the cycle its flag is consumed re-arms the flag for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_set <= 1'b0;
      pend_rst <= 1'b0;
      conflict <= 1'b0;
    end else begin
      pend_set <= (pend_set & ~take_set) | rise_set_eff;
      pend_rst <= (pend_rst & ~take_rst) | rise[1];
      conflict <= rise[0] & rise[1];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Latched command and the gate-window cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_rst  <= 1'b0;
      gate_cnt <= '0;
    end else begin
      if (take_rst || take_set) begin
        cmd_rst <= take_rst;
      end
      if (state == SETUP) begin
        gate_cnt <= '0;
      end else if (state == GATE) begin
        gate_cnt <= gate_cnt + GATE_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pend_rst || pend_set) next_state = SETUP;
      SETUP:   next_state = GATE;
      GATE:    if (gate_cnt == GATE_LAST) next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decode from registered state and command only, so nothing on
  // the button pins reaches them combinationally.
  always_comb begin
    S    = 1'b0;
    R    = 1'b0;
    C    = 1'b0;
    busy = 1'b0;
    if (state != IDLE) begin
      busy = 1'b1;
      S    = ~cmd_rst;
      R    = cmd_rst;
      C    = (state == GATE);
    end
  end

endmodule
